ms2xs_sparse: RTL and testbench
===============================

MS2XS_SPARSE -- requirements
Module: ms2xs_sparse

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, AXI-Stream data width.
REQ-002 SHALL have parameter N, default 11, polynomial degree (number of coefficients).
REQ-003 SHALL have parameter QW, default 11, coefficient width; q = 2^QW.
REQ-004 SHALL have parameter M, default 1, number of parallel arithmetic lanes, 1..N.
REQ-005 SHALL have parameter MAX_NNZ, default 7, capacity of the nonzero-index list for r.
REQ-006 SHALL be clocked by clk (input, 1, rising edge) and reset by reset (input, 1, synchronous, active-low).
REQ-007 SHALL have din_tdata (input, D_WIDTH): [QW+3:4] h coeff; [3:2] r (00=0, 01=+1, 11=-1, 10=0); [1:0] m (bit1=1 -> q-1, else value); [25:24] tag.
REQ-008 SHALL have din_tvalid, din_tlast (input, 1) and din_tready (output, 1).
REQ-009 SHALL have acc_en (input, 1): 1 initialises e to m, 0 initialises e to 0; sampled on first input beat.
REQ-010 SHALL have dout_tdata (output, D_WIDTH): [QW-1:0] e coeff, [QW+1:QW] tag, upper bits 0.
REQ-011 SHALL have dout_tvalid, dout_tlast (output, 1) and dout_tready (input, 1).
REQ-012 SHALL have mult_done (output, 1, one-cycle pulse) and err (output, 1, sticky until next first input beat).

Function
REQ-013 SHALL compute e = init + r*h mod (x^N - 1), all coefficient arithmetic truncated to QW bits (mod q).
REQ-014 SHALL use FSM states IDLE, LOAD, MULT, OUT; IDLE->LOAD on first din handshake.
REQ-015 SHALL assert din_tready only in IDLE and LOAD; beat k (0..N-1) writes h[k], m[k], r[k].
REQ-016 SHALL, on each beat with r[k]!=0, append (k, sign) to the index list and increment nnz.
REQ-017 SHALL enter MULT after beat N-1; din_tlast on beat N-1 is optional; din_tlast on beat k<N-1 sets err, zero-fills the remaining coefficients, and enters MULT.
REQ-018 SHALL set err when nnz would exceed MAX_NNZ; further entries are dropped; all output coefficients are then 0.
REQ-019 SHALL, in MULT, spend 1 setup cycle, then CH = ceil(N/M) cycles per list entry, updating e[(i+j) mod N] +/- h[j] for M consecutive j per cycle; lanes with j>=N are inactive.
REQ-020 SHALL therefore raise dout_tvalid first at cycle T+2+nnz*CH, where T is the cycle of the last input handshake; nnz=0 gives T+2.
REQ-021 SHALL, in OUT, emit e[0..N-1] in order, one per dout handshake; data held stable while dout_tvalid=1 and dout_tready=0.
REQ-022 SHALL assert dout_tlast with e[N-1] only, echo the tag captured on beat 0 on every output beat, pulse mult_done in the cycle after the last output handshake, and return to IDLE.

Reset
REQ-023 SHALL, on reset=0, drive din_tready=0, dout_tvalid=0, dout_tlast=0, dout_tdata=0, mult_done=0, err=0, nnz=0, state IDLE, regardless of current state (including mid-MULT and mid-OUT).
REQ-024 SHALL NOT require clearing of the h, m, e storage; every location is rewritten before it is read.

Structure
REQ-025 SHALL place a clog2 function, CH derivation, and r-encoding constants in shared package ntru_pkg.
REQ-026 SHALL instantiate one sub-module, ntru_lane_au (one per lane): QW-bit add/subtract of h into e, selected by sign, with an enable.

Verification
REQ-027 N=11, QW=11, M=2: r=+1@0, h[i]=i, acc_en=0 -> e[i]=i; first dout_tvalid at T+8.
REQ-028 r=-1@1, all h=1, acc_en=0 -> every e=2047.
REQ-029 Wrap-around: r=+1@10, h=delta@1 -> e[0]=1, all others 0.
REQ-030 acc_en=1, m bit1 set on all beats, r all 0 -> every e=2047; dout_tvalid at T+2; tag 2'b10 echoed.
REQ-031 8 nonzero r with MAX_NNZ=7 -> err=1, all e=0; din_tlast on beat 5 -> err=1, MULT starts.
REQ-032 Random dout_tready toggling, then reset=0 mid-MULT -> outputs at reset values, next frame correct.

Source files
------------

// File: rtl/ntru_pkg.sv
// Shared definitions for the sparse ternary polynomial multiplier.
//   clog2 / idx_width : index width helpers
//   ch_count          : cycles needed to sweep N coefficients with M lanes
//   R_*               : encodings of the ternary r coefficient in the input beat
//   state_t           : multiplier FSM states
package ntru_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned res;
        res = 0;
        for (longint unsigned p = 1; p < v; p = p << 1) begin
            res++;
        end
        return res;
    endfunction

    // Never returns 0 so it can size a vector directly.
    function automatic int unsigned idx_width(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

    function automatic int unsigned ch_count(input int unsigned n, input int unsigned m);
        return (n + m - 1) / m;
    endfunction

    localparam logic [1:0] R_ZERO     = 2'b00;
    localparam logic [1:0] R_POS      = 2'b01;
    localparam logic [1:0] R_ZERO_ALT = 2'b10;
    localparam logic [1:0] R_NEG      = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, MULT, OUT} state_t;

endpackage

// File: rtl/ntru_lane_au.sv
// One arithmetic lane: e_next = e_cur +/- h_coef (mod 2^QW) when enabled.
//   en     : lane active this cycle (otherwise e_cur passes through)
//   sub    : 1 -> subtract, 0 -> add
//   e_cur  : current accumulator coefficient
//   h_coef : h coefficient to fold in
//   e_next : updated coefficient
module ntru_lane_au
    import ntru_pkg::*;
#(
    parameter int unsigned QW = 11
) (
    input  logic          en,
    input  logic          sub,
    input  logic [QW-1:0] e_cur,
    input  logic [QW-1:0] h_coef,
    output logic [QW-1:0] e_next
);

    always_comb begin
        e_next = e_cur;
        if (en) begin
            e_next = sub ? (e_cur - h_coef) : (e_cur + h_coef);
        end
    end

endmodule

// File: rtl/ms2xs_sparse.sv
// Sparse ternary polynomial multiply-accumulate: e = init + r*h mod (x^N - 1), mod 2^QW.
//   clk, reset           : clock, synchronous active-low reset
//   din_*                : AXI-Stream input, one beat per coefficient (h, r, m, tag)
//   acc_en               : sampled on beat 0; 1 -> e starts at m, 0 -> e starts at 0
//   dout_*               : AXI-Stream output, e[0..N-1] with the captured tag
//   mult_done            : pulse the cycle after the final output handshake
//   err                  : sticky error (early tlast or index-list overflow)
module ms2xs_sparse
    import ntru_pkg::*;
#(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned N       = 11,
    parameter int unsigned QW      = 11,
    parameter int unsigned M       = 1,
    parameter int unsigned MAX_NNZ = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] din_tdata,
    input  logic               din_tvalid,
    input  logic               din_tlast,
    output logic               din_tready,
    input  logic               acc_en,
    output logic [D_WIDTH-1:0] dout_tdata,
    output logic               dout_tvalid,
    output logic               dout_tlast,
    input  logic               dout_tready,
    output logic               mult_done,
    output logic               err
);

    localparam int unsigned CH = ch_count(N, M);
    localparam int unsigned IW = idx_width(N);
    localparam int unsigned JW = idx_width(2 * N + M) + 1;
    localparam int unsigned CW = idx_width(CH);
    localparam int unsigned NW = idx_width(MAX_NNZ + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q;  // input beat index, then output index
    logic [NW-1:0] nnz_q, nnz_d, ent_q;
    logic [CW-1:0] ch_q;
    logic          setup_q, acc_q, ovf_q, ovf_d, err_q, err_d, done_q;
    logic [1:0]    tag_q;

    logic [QW-1:0] h_q [N];
    logic [QW-1:0] e_q [N];
    logic [IW-1:0] idx_q [MAX_NNZ];
    logic          neg_q [MAX_NNZ];

    logic          din_hs, dout_hs, first_beat, last_idx, early_last, beat_end;
    logic          r_nz, r_neg, append, mult_run, ch_last, ent_last;
    logic [1:0]    r_code;
    logic [QW-1:0] din_h, din_m, init_m;
    logic [NW-1:0] slot;

    logic          unused_din;
    assign unused_din = ^{din_tdata[D_WIDTH-1:26], din_tdata[23:QW+4]};

    assign din_tready = reset && (state_q == IDLE || state_q == LOAD);
    assign din_hs     = din_tvalid && din_tready;
    assign dout_hs    = dout_tvalid && dout_tready;
    assign first_beat = (state_q == IDLE);
    assign last_idx   = (cnt_q == IW'(N - 1));
    assign early_last = din_tlast && !last_idx;
    assign beat_end   = last_idx || din_tlast;

    assign din_h  = din_tdata[QW+3:4];
    assign din_m  = din_tdata[1] ? '1 : QW'(din_tdata[0]);
    assign init_m = (first_beat ? acc_en : acc_q) ? din_m : '0;
    assign r_code = din_tdata[3:2];
    assign r_nz   = (r_code == R_POS) || (r_code == R_NEG);
    assign r_neg  = (r_code == R_NEG);
    assign slot   = first_beat ? '0 : nnz_q;

    assign mult_run = (state_q == MULT) && !setup_q;
    assign ch_last  = (ch_q == CW'(CH - 1));
    assign ent_last = (ent_q == nnz_q - NW'(1));

    // Index list bookkeeping; a new frame restarts from an empty list.
    always_comb begin
        nnz_d  = nnz_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        append = 1'b0;
        if (din_hs) begin
            if (first_beat) begin
                nnz_d = '0;
                ovf_d = 1'b0;
                err_d = 1'b0;
            end
            if (r_nz) begin
                if (nnz_d == NW'(MAX_NNZ)) begin
                    ovf_d = 1'b1;
                    err_d = 1'b1;
                end else begin
                    append = 1'b1;
                    nnz_d  = nnz_d + NW'(1);
                end
            end
            if (early_last) begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: if (din_hs) state_d = beat_end ? MULT : LOAD;
            MULT: if (setup_q ? (nnz_q == '0) : (ch_last && ent_last)) state_d = OUT;
            OUT: if (dout_hs && last_idx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nnz_q   <= '0;
            ent_q   <= '0;
            ch_q    <= '0;
            setup_q <= 1'b0;
            acc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            nnz_q   <= nnz_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= dout_hs && last_idx;
            if (din_hs) begin
                cnt_q <= beat_end ? '0 : cnt_q + IW'(1);
                if (first_beat) begin
                    acc_q <= acc_en;
                    tag_q <= din_tdata[25:24];
                end
                if (beat_end) begin
                    setup_q <= 1'b1;
                    ent_q   <= '0;
                    ch_q    <= '0;
                end
            end
            if (state_q == MULT) begin
                if (setup_q) begin
                    setup_q <= 1'b0;
                end else if (ch_last) begin
                    ch_q  <= '0;
                    ent_q <= ent_q + NW'(1);
                end else begin
                    ch_q <= ch_q + CW'(1);
                end
            end
            if (dout_hs) begin
                cnt_q <= last_idx ? '0 : cnt_q + IW'(1);
            end
        end
    end

    // Lane l handles j = ch*M + l and targets e[(i + j) mod N] for list entry i.
    logic [JW-1:0] lane_j [M];
    logic [JW-1:0] lane_s [M];
    logic [IW-1:0] lane_t [M];
    logic [IW-1:0] lane_hi [M];
    logic          lane_act [M];
    logic [QW-1:0] lane_e [M];

    always_comb begin
        for (int l = 0; l < M; l++) begin
            lane_j[l]   = JW'(ch_q) * JW'(M) + JW'(l);
            lane_act[l] = mult_run && (lane_j[l] < JW'(N));
            lane_s[l]   = JW'(idx_q[ent_q]) + lane_j[l];
            if (lane_s[l] >= JW'(N)) begin
                lane_s[l] = lane_s[l] - JW'(N);
            end
            lane_t[l]  = IW'(lane_s[l]);
            lane_hi[l] = IW'(lane_j[l]);
        end
    end

    for (genvar l = 0; l < M; l++) begin : g_lane
        ntru_lane_au #(
            .QW(QW)
        ) u_au (
            .en     (lane_act[l]),
            .sub    (neg_q[ent_q]),
            .e_cur  (e_q[lane_t[l]]),
            .h_coef (h_q[lane_hi[l]]),
            .e_next (lane_e[l])
        );
    end

    // Storage is not reset: every location is written during load before use.
    always_ff @(posedge clk) begin
        if (din_hs) begin
            for (int k = 0; k < N; k++) begin
                if (IW'(k) == cnt_q) begin
                    h_q[k] <= din_h;
                    e_q[k] <= init_m;
                end else if (early_last && IW'(k) > cnt_q) begin
                    h_q[k] <= '0;
                    e_q[k] <= '0;
                end
            end
            if (append) begin
                idx_q[slot] <= cnt_q;
                neg_q[slot] <= r_neg;
            end
        end
        for (int l = 0; l < M; l++) begin
            if (lane_act[l]) begin
                e_q[lane_t[l]] <= lane_e[l];
            end
        end
    end

    always_comb begin
        dout_tdata = '0;
        if (state_q == OUT) begin
            dout_tdata[QW+1:QW] = tag_q;
            if (!ovf_q) begin
                dout_tdata[QW-1:0] = e_q[cnt_q];
            end
        end
    end

    assign dout_tvalid = (state_q == OUT);
    assign dout_tlast  = dout_tvalid && last_idx;
    assign mult_done   = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ms2xs_sparse.sv
// Directed bench for ms2xs_sparse with N=11, QW=11, M=2 (CH=6), MAX_NNZ=7.
module tb_ms2xs_sparse;

    localparam int N  = 11;
    localparam int QW = 11;

    logic        clk;
    logic        reset;
    logic [31:0] din_tdata;
    logic        din_tvalid, din_tlast, din_tready, acc_en;
    logic [31:0] dout_tdata;
    logic        dout_tvalid, dout_tlast, dout_tready, mult_done, err;

    ms2xs_sparse #(
        .D_WIDTH(32), .N(N), .QW(QW), .M(2), .MAX_NNZ(7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din_tdata   (din_tdata),
        .din_tvalid  (din_tvalid),
        .din_tlast   (din_tlast),
        .din_tready  (din_tready),
        .acc_en      (acc_en),
        .dout_tdata  (dout_tdata),
        .dout_tvalid (dout_tvalid),
        .dout_tlast  (dout_tlast),
        .dout_tready (dout_tready),
        .mult_done   (mult_done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs  = 0;
    int fails = 0;
    int t_last = 0;

    logic [QW-1:0] fh [N];
    logic [1:0]    fr [N];
    logic [1:0]    fm [N];
    logic [1:0]    ftag;
    logic          facc;
    logic [QW-1:0] exp_e [N];

    task automatic clear_frame();
        for (int k = 0; k < N; k++) begin
            fh[k] = '0; fr[k] = 2'b00; fm[k] = 2'b00; exp_e[k] = '0;
        end
        ftag = 2'b01;
        facc = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input bit last_on_final);
        logic [31:0] w;
        int g;
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clk);
            w = '0;
            w[14:4]  = fh[k];
            w[3:2]   = fr[k];
            w[1:0]   = fm[k];
            w[25:24] = ftag;
            din_tdata  = w;
            din_tvalid = 1'b1;
            din_tlast  = (k == nbeats - 1) && last_on_final;
            acc_en     = (k == 0) ? facc : ~facc;  // only beat 0 may matter
            g = 0;
            while (!din_tready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!din_tready) begin
                vecs++; fails++;
                $display("FAIL din_tready_timeout: beat %0d got ready=0 required 1", k);
            end
            t_last = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        din_tvalid = 1'b0;
        din_tlast  = 1'b0;
    endtask

    task automatic wait_valid(input int exp_cyc, input string name);
        int g = 0;
        dout_tready = 1'b0;
        while (!dout_tvalid && g < 200) begin
            @(negedge clk);
            g++;
        end
        vecs++;
        if (dout_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: got dout_tvalid=%b required 1", name, dout_tvalid);
        end
        if (exp_cyc >= 0) begin
            vecs++;
            if (cyc != exp_cyc) begin
                fails++;
                $display("FAIL %s_latency: got cycle %0d required %0d", name, cyc, exp_cyc);
            end
        end
    endtask

    task automatic collect(input bit rnd, input string name);
        int i = 0;
        int g = 0;
        bit hold_chk = 1'b0;
        logic [31:0] held, exp_w;
        while (i < N && g < 400) begin
            @(negedge clk);
            g++;
            if (hold_chk) begin
                vecs++;
                if (dout_tdata !== held || dout_tvalid !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_hold: got %h valid=%b required %h valid=1",
                             name, dout_tdata, dout_tvalid, held);
                end
            end
            dout_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold_chk = dout_tvalid && !dout_tready;
            held = dout_tdata;
            if (dout_tvalid && dout_tready) begin
                exp_w = '0;
                exp_w[QW+1:QW] = ftag;
                exp_w[QW-1:0]  = exp_e[i];
                vecs++;
                if (dout_tdata !== exp_w) begin
                    fails++;
                    $display("FAIL %s_e%0d: got %h required %h", name, i, dout_tdata, exp_w);
                end
                vecs++;
                if (dout_tlast !== (i == N - 1)) begin
                    fails++;
                    $display("FAIL %s_tlast%0d: got %b required %b", name, i, dout_tlast,
                             (i == N - 1));
                end
                i++;
            end
        end
        if (i < N) begin
            vecs++; fails++;
            $display("FAIL %s_out_timeout: got %0d beats required %0d", name, i, N);
        end
        dout_tready = 1'b1;
        @(negedge clk);
        vecs++;
        if (mult_done !== 1'b1 || dout_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: got mult_done=%b valid=%b required 1,0", name, mult_done,
                     dout_tvalid);
        end
        @(negedge clk);
        vecs++;
        if (mult_done !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse: got mult_done=%b required 0", name, mult_done);
        end
    endtask

    task automatic check_err(input logic exp, input string name);
        vecs++;
        if (err !== exp) begin
            fails++;
            $display("FAIL %s_err: got %b required %b", name, err, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vecs++;
        if (din_tready !== 1'b0 || dout_tvalid !== 1'b0 || dout_tlast !== 1'b0 ||
            dout_tdata !== 32'h0 || mult_done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s: got rdy=%b vld=%b last=%b data=%h done=%b err=%b required all 0",
                     name, din_tready, dout_tvalid, dout_tlast, dout_tdata, mult_done, err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b1;
        @(negedge clk);
        vecs++;
        if (din_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 1", din_tready);
        end
    endtask

    // r=+1@0, h[i]=i, m ignored because acc_en=0 on beat 0.
    task automatic test_single_pos();
        clear_frame();
        for (int k = 0; k < N; k++) begin
            fh[k] = QW'(k); fm[k] = 2'b10; exp_e[k] = QW'(k);
        end
        fr[0] = 2'b01;
        send_frame(N, 1'b0);
        wait_valid(t_last + 8, "single_pos");
        check_err(1'b0, "single_pos");
        collect(1'b0, "single_pos");
    endtask

    // tlast on beat 5: remaining h/e zero-filled, err set, MULT entered.
    task automatic test_early_last();
        clear_frame();
        for (int k = 0; k <= 5; k++) begin
            fh[k] = QW'(k + 1); exp_e[k] = QW'(k + 1);
        end
        fr[0] = 2'b01;
        ftag = 2'b11;
        send_frame(6, 1'b1);
        vecs++;
        if (din_tready !== 1'b0) begin
            fails++;
            $display("FAIL early_last_mult: got din_tready=%b required 0", din_tready);
        end
        check_err(1'b1, "early_last");
        wait_valid(t_last + 8, "early_last");
        collect(1'b0, "early_last");
    endtask

    // r=-1@1, all h=1: every coefficient becomes 0 - 1 = 2047; random backpressure.
    task automatic test_neg_ones();
        clear_frame();
        for (int k = 0; k < N; k++) begin
            fh[k] = 11'd1; exp_e[k] = 11'd2047;
        end
        fr[1] = 2'b11;
        fr[4] = 2'b10;  // alternate zero encoding must not enter the list
        send_frame(N, 1'b1);
        wait_valid(t_last + 8, "neg_ones");
        check_err(1'b0, "neg_ones");
        collect(1'b1, "neg_ones");
    endtask

    task automatic test_wrap();
        clear_frame();
        fh[1] = 11'd1;
        fr[10] = 2'b01;
        exp_e[0] = 11'd1;
        ftag = 2'b00;
        send_frame(N, 1'b1);
        wait_valid(t_last + 8, "wrap");
        collect(1'b0, "wrap");
    endtask

    task automatic test_acc_en();
        clear_frame();
        for (int k = 0; k < N; k++) begin
            fh[k] = 11'd5; fm[k] = 2'b10; exp_e[k] = 11'd2047;
        end
        facc = 1'b1;
        ftag = 2'b10;
        send_frame(N, 1'b1);
        wait_valid(t_last + 2, "acc_en");
        collect(1'b0, "acc_en");
    endtask

    // Eight nonzero r overflow a 7-entry list: err and all-zero output.
    task automatic test_overflow();
        clear_frame();
        for (int k = 0; k < N; k++) fh[k] = 11'd1;
        for (int k = 0; k < 8; k++) fr[k] = 2'b01;
        ftag = 2'b01;
        send_frame(N, 1'b1);
        check_err(1'b1, "overflow");
        wait_valid(-1, "overflow");
        collect(1'b0, "overflow");
        check_err(1'b1, "overflow_sticky");
    endtask

    task automatic test_reset_mid_mult();
        clear_frame();
        for (int k = 0; k < 3; k++) begin
            fr[k] = 2'b01; fh[k] = 11'd7;
        end
        send_frame(4, 1'b1);
        repeat (3) @(negedge clk);
        check_err(1'b1, "pre_reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_mult");
        @(negedge clk);
        reset = 1'b1;
        // Next frame: r=-1@0, h[2]=3 -> e[2] = 2048-3 = 2045.
        clear_frame();
        fr[0] = 2'b11;
        fh[2] = 11'd3;
        exp_e[2] = 11'd2045;
        ftag = 2'b10;
        send_frame(N, 1'b0);
        wait_valid(t_last + 8, "after_reset");
        check_err(1'b0, "after_reset");
        collect(1'b1, "after_reset");
    endtask

    initial begin
        reset       = 1'b0;
        din_tdata   = '0;
        din_tvalid  = 1'b0;
        din_tlast   = 1'b0;
        acc_en      = 1'b0;
        dout_tready = 1'b0;
        test_reset();
        test_single_pos();
        test_early_last();
        test_neg_ones();
        test_wrap();
        test_acc_en();
        test_overflow();
        test_reset_mid_mult();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
